// File: rtl/add8_operand_feeder.sv
// add8_operand_feeder
//   Staging stage in front of an external combinational 8-bit adder (sum only,
//   carry discarded). Operand pairs are buffered in a small FIFO. The head pair
//   is driven onto the adder inputs straight from registers. The adder's sum is
//   captured into a registered output slot with valid/ready handshaking.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand-pair stream; in_ready = FIFO not full
//   in_a, in_b           operands A and B
//   add_a, add_b         FIFO head, to adder x0..x7 / x8..x15 (bit0 = x0 / x8)
//   add_sum              adder result y0..y7 = (add_a + add_b) mod 256
//   out_valid/out_ready  result stream; out_sum is registered
//   out_sum              registered sum
//   level                FIFO occupancy, 0..DEPTH
module add8_operand_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  input  logic [W-1:0]             add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_sum,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_sum_q,   out_sum_d;

  logic push;
  logic pop;
  logic slot_free;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign slot_free = ~out_valid_q | out_ready;
  // Pop is gated by the registered level, so a pair pushed into an empty
  // FIFO is only visible to the adder from the following cycle.
  assign pop       = (level_q != '0) & slot_free;

  assign add_a     = mem_a_q[rd_ptr_q];
  assign add_b     = mem_b_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign level     = level_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      if (push) begin
        mem_a_q[wr_ptr_q] <= in_a;
        mem_b_q[wr_ptr_q] <= in_b;
      end
    end
  end

endmodule

// File: tb/tb_add8_operand_feeder.sv
module tb_add8_operand_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [2:0]   level;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  // Reference adder closing the loop
  assign add_sum = add_a + add_b;

  add8_operand_feeder #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=completion", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes sampled mid-cycle complete at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(W'(in_a + in_b));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_empty: observed=%0h expected=none", out_sum);
        end else begin
          chk("sb_sum", 32'(out_sum), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic rdy;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 200; i++) begin
      rdy = in_ready;
      step();
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    fail_timeout("send");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (level == 0 && !out_valid) return;
      step();
    end
    fail_timeout("drain");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // 1: reset mid-stream with level=3 and a pending result
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = W'(8'h10 + i); in_b = W'(8'h20); step();
    end
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    sb_q.delete();
    n_in = 0; n_out = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_out_sum", 32'(out_sum), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_add_a", 32'(add_a), 0);
    chk("post_rst_add_b", 32'(add_b), 0);

    // 2: single pair, latency one edge after acceptance
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h03;
    step();
    in_valid = 1'b0;
    chk("single_level", 32'(level), 1);
    chk("single_ov0", 32'(out_valid), 0);
    step();
    chk("single_ov1", 32'(out_valid), 1);
    chk("single_sum", 32'(out_sum), 32'h08);
    step();
    chk("single_ov_clear", 32'(out_valid), 0);
    chk("single_sum_hold", 32'(out_sum), 32'h08);

    // 3: modulo-256 wrap cases
    send(8'hFF, 8'h01);
    step();
    chk("wrap_ff_01", 32'(out_sum), 32'h00);
    send(8'h80, 8'h80);
    step();
    chk("wrap_80_80", 32'(out_sum), 32'h00);
    send(8'hAA, 8'h55);
    step();
    chk("sum_aa_55", 32'(out_sum), 32'hFF);
    drain();

    // 4: backpressure until full, then release
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(W'(i), W'(i));
    chk("full_level", 32'(level), DEPTH);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    step(); step();
    chk("bp_sum_stable", 32'(out_sum), 32'h02);
    chk("bp_level_stable", 32'(level), DEPTH);
    drain();

    // 5: streaming, one result per cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = W'($urandom); in_b = W'($urandom);
      step();
      chk("stream_level_le1", 32'(level <= 1), 1);
      if (i >= 1) chk("stream_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    drain();

    // 6: simultaneous push+pop at level=DEPTH-1
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(W'(8'h30 + i), W'(8'h01));
    chk("pp_pre_level", 32'(level), DEPTH - 1);
    in_valid = 1'b1; in_a = 8'h40; in_b = 8'h02; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_level_unchanged", 32'(level), DEPTH - 1);
    drain();

    // Pointer wrap over three full FIFO cycles
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom));
      chk("wrap_round_full", 32'(level), DEPTH);
      drain();
    end

    step(); step();
    chk("sb_all_out", 32'(n_out), 32'(n_in));
    chk("sb_empty_end", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
